// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 matrix keypad one column at a time, debounces over whole
//   scans, encodes a single pressed key to its hex code and queues each new
//   key press in a 2-entry event FIFO drained through a valid/ready handshake.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   col[3:0]   column drive, active-low, one column low at a time
//   row[3:0]   row sense, active-low, asynchronous to clk
//   key_valid  FIFO head holds an event
//   key_code   hex code of the FIFO head (0 when empty)
//   key_ready  consumer pops the head when key_valid && key_ready
//   key_down   debounced level: exactly one key held
//   overflow   sticky: an event was dropped because the FIFO was full
//   ovf_clr    one-cycle pulse clearing overflow (a same-cycle set wins)
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int STB_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  // Scan result: hit=0 means NONE (no key or several keys).
  typedef struct packed {
    logic       hit;
    logic [3:0] code;
  } res_t;

  localparam res_t RES_NONE = '0;

  // Hex code of the key at row r, column c.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] k;
    k = '0;
    case ({r, c})
      4'h0: k = 4'h1;
      4'h1: k = 4'h2;
      4'h2: k = 4'h3;
      4'h3: k = 4'hA;
      4'h4: k = 4'h4;
      4'h5: k = 4'h5;
      4'h6: k = 4'h6;
      4'h7: k = 4'hB;
      4'h8: k = 4'h7;
      4'h9: k = 4'h8;
      4'hA: k = 4'h9;
      4'hB: k = 4'hC;
      4'hC: k = 4'h0;
      4'hD: k = 4'hF;
      4'hE: k = 4'hE;
      4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  // Matrix bit index is col*4 + row. Anything other than exactly one set
  // bit (idle, multi-key, ghosting) collapses to NONE.
  function automatic res_t encode(input logic [15:0] m);
    res_t       res;
    int         ones;
    logic [3:0] idx;
    res  = RES_NONE;
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        idx      = 4'(i);
        ones     = ones + 1;
        res.hit  = 1'b1;
        res.code = key_map(idx[1:0], idx[3:2]);
      end
    end
    if (ones != 1) res = RES_NONE;
    return res;
  endfunction

  function automatic logic [STB_W-1:0] sat_inc(input logic [STB_W-1:0] v);
    return (v >= STB_MAX) ? STB_MAX : v + STB_W'(1);
  endfunction

  // Control state (reset)
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [STB_W-1:0] stb_q, stb_d;
  res_t             prev_q, prev_d;
  res_t             deb_q, deb_d;
  logic             head_vld_q, head_vld_d;
  logic             tail_vld_q, tail_vld_d;
  logic [3:0]       head_q, head_d;
  logic             ovf_q, ovf_d;

  // Data path state (no reset; always rewritten before use)
  logic [3:0]  meta_q, meta_d;
  logic [3:0]  rs_q, rs_d;
  logic [11:0] samp_q, samp_d;
  logic [3:0]  tail_q, tail_d;

  logic       dwell_end;
  logic       scan_end;
  res_t       scan_res;
  logic       push;
  logic [3:0] push_code;
  logic       pop;
  logic       ovf_set;

  always_comb begin
    meta_d     = row;
    rs_d       = meta_q;
    samp_d     = samp_q;
    tail_d     = tail_q;
    cyc_d      = cyc_q;
    col_idx_d  = col_idx_q;
    stb_d      = stb_q;
    prev_d     = prev_q;
    deb_d      = deb_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    head_d     = head_q;
    push       = 1'b0;
    push_code  = '0;
    ovf_set    = 1'b0;

    // Column dwell: sample at end of dwell so the rows have settled.
    dwell_end = (cyc_q == CYC_LAST);
    scan_end  = dwell_end && (col_idx_q == 2'd3);
    cyc_d     = dwell_end ? '0 : cyc_q + CNT_W'(1);
    if (dwell_end) begin
      col_idx_d = col_idx_q + 2'd1;
      case (col_idx_q)
        2'd0:    samp_d[3:0]  = ~rs_q;
        2'd1:    samp_d[7:4]  = ~rs_q;
        2'd2:    samp_d[11:8] = ~rs_q;
        default: ;
      endcase
    end

    // Column 3 is taken straight from the synchronizer on the last dwell.
    scan_res = encode({~rs_q, samp_q});

    // Debounce over whole scans; every debounced entry into a key is an event.
    if (scan_end) begin
      prev_d = scan_res;
      stb_d  = (scan_res == prev_q) ? sat_inc(stb_q) : STB_W'(1);
      if ((stb_d == STB_MAX) && (scan_res != deb_q)) begin
        deb_d     = scan_res;
        push      = scan_res.hit;
        push_code = scan_res.code;
      end
    end

    // Pop first so a push into a full FIFO on a pop cycle finds room.
    pop = head_vld_q && key_ready;
    if (pop) begin
      if (tail_vld_q) begin
        head_d     = tail_q;
        tail_vld_d = 1'b0;
      end else begin
        head_vld_d = 1'b0;
        head_d     = '0;
      end
    end
    if (push) begin
      if (!head_vld_d) begin
        head_vld_d = 1'b1;
        head_d     = push_code;
      end else if (!tail_vld_d) begin
        tail_vld_d = 1'b1;
        tail_d     = push_code;
      end else begin
        ovf_set = 1'b1;
      end
    end

    ovf_d = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q      <= '0;
      col_idx_q  <= '0;
      stb_q      <= '0;
      prev_q     <= RES_NONE;
      deb_q      <= RES_NONE;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
      head_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      cyc_q      <= cyc_d;
      col_idx_q  <= col_idx_d;
      stb_q      <= stb_d;
      prev_q     <= prev_d;
      deb_q      <= deb_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
      head_q     <= head_d;
      ovf_q      <= ovf_d;
    end
  end

  // Row synchronizer and column sample slots
  always_ff @(posedge clk) begin
    meta_q <= meta_d;
    rs_q   <= rs_d;
    samp_q <= samp_d;
    tail_q <= tail_d;
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_valid = head_vld_q;
  assign key_code  = head_q;
  assign key_down  = deb_q.hit;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad model and an
// event scoreboard (expected codes queued at stimulus time, compared when
// the DUT hands over an event).
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       key_down;
  logic       overflow;
  logic       ovf_clr;

  logic [15:0] keys;      // pressed keys, index r*4+c
  logic [3:0]  exp_q[$];
  int          checks;
  int          errors;
  int          nev;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_down  (key_down),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: row r pulled low while column c is driven low and (r,c) pressed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard check at the falling edge, then inputs may change
  // 1 time unit after the rising edge.
  task automatic step();
    logic [3:0] e;
    @(negedge clk);
    if (key_valid && key_ready) begin
      nev++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL event_unexpected observed=%h expected=no event", key_code);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk4("event_code", key_code, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int r, input int c, input logic v);
    keys[r*4+c] = v;
  endtask

  task automatic wait_kd(input logic v, input int bound, input string tag);
    int n;
    n = 0;
    while (key_down !== v && n < bound) begin
      step();
      n++;
    end
    chk1(tag, key_down, v);
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      step();
      n++;
    end
    chkn(tag, exp_q.size(), 0);
  endtask

  initial begin
    int         nev0;
    logic [3:0] exp_col;
    checks    = 0;
    errors    = 0;
    nev       = 0;
    rst       = 1'b1;
    key_ready = 1'b1;
    ovf_clr   = 1'b0;
    keys      = '0;

    // Reset then idle scanning
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk4("rst_col", col, 4'b1110);
    chk1("rst_valid", key_valid, 1'b0);
    chk4("rst_code", key_code, 4'h0);
    chk1("rst_down", key_down, 1'b0);
    chk1("rst_ovf", overflow, 1'b0);
    for (int n = 0; n < 16; n++) begin
      exp_col = 4'b0001 << (n / 4);
      exp_col = ~exp_col;
      chk4("scan_col", col, exp_col);
      step();
    end
    repeat (32) step();
    chk1("idle_valid", key_valid, 1'b0);
    chk1("idle_down", key_down, 1'b0);
    chk1("idle_ovf", overflow, 1'b0);

    // Single press of '6' with consumer ready
    nev0 = nev;
    exp_q.push_back(4'h6);
    set_key(1, 2, 1'b1);
    wait_kd(1'b1, 52, "press6_down");
    wait_drain(20, "press6_event");
    set_key(1, 2, 1'b0);
    wait_kd(1'b0, 52, "rel6_down");
    repeat (40) step();
    chkn("press6_count", nev - nev0, 1);

    // Bounce '0' on alternate scans, then hold
    nev0 = nev;
    for (int k = 0; k < 6; k++) begin
      set_key(3, 0, (k % 2) == 0);
      repeat (16) step();
    end
    chk1("bounce_down", key_down, 1'b0);
    chkn("bounce_events", nev - nev0, 0);
    exp_q.push_back(4'h0);
    set_key(3, 0, 1'b1);
    wait_kd(1'b1, 52, "hold0_down");
    wait_drain(20, "hold0_event");
    set_key(3, 0, 1'b0);
    wait_kd(1'b0, 52, "rel0_down");

    // Two keys '1' and '2' together, then release '2'
    nev0 = nev;
    set_key(0, 0, 1'b1);
    set_key(0, 1, 1'b1);
    repeat (64) step();
    chk1("multi_down", key_down, 1'b0);
    chkn("multi_events", nev - nev0, 0);
    exp_q.push_back(4'h1);
    set_key(0, 1, 1'b0);
    wait_kd(1'b1, 52, "single1_down");
    wait_drain(20, "single1_event");
    set_key(0, 0, 1'b0);
    wait_kd(1'b0, 52, "rel1_down");

    // FIFO fill and overflow with consumer stalled: A, B kept, C dropped
    key_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (r < 2) exp_q.push_back(4'hA + 4'(r));
      set_key(r, 3, 1'b1);
      wait_kd(1'b1, 52, "fill_down");
      set_key(r, 3, 1'b0);
      wait_kd(1'b0, 52, "fill_up");
      if (r == 1) chk1("full_no_ovf", overflow, 1'b0);
    end
    chk1("ovf_valid", key_valid, 1'b1);
    chk4("ovf_head_held", key_code, 4'hA);
    chk1("ovf_set", overflow, 1'b1);
    key_ready = 1'b1;
    step();
    step();
    key_ready = 1'b0;
    chk1("drained_valid", key_valid, 1'b0);
    chk4("drained_code", key_code, 4'h0);
    chkn("drained_sb", exp_q.size(), 0);
    chk1("ovf_sticky", overflow, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk1("ovf_cleared", overflow, 1'b0);

    // Reset during debounce of 'D', with a stale '5' in the FIFO
    set_key(1, 1, 1'b1);
    wait_kd(1'b1, 52, "five_down");
    set_key(1, 1, 1'b0);
    wait_kd(1'b0, 52, "five_up");
    chk1("five_valid", key_valid, 1'b1);
    chk4("five_code", key_code, 4'h5);
    set_key(3, 3, 1'b1);
    repeat (12) step();
    chk1("pre_rst_down", key_down, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk4("mid_rst_col", col, 4'b1110);
    chk1("mid_rst_valid", key_valid, 1'b0);
    chk4("mid_rst_code", key_code, 4'h0);
    chk1("mid_rst_down", key_down, 1'b0);
    chk1("mid_rst_ovf", overflow, 1'b0);
    nev0 = nev;
    key_ready = 1'b1;
    exp_q.push_back(4'hD);
    wait_drain(70, "d_event");
    set_key(3, 3, 1'b0);
    wait_kd(1'b0, 52, "d_up");
    repeat (32) step();
    chkn("d_count", nev - nev0, 1);
    chkn("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
